// File: rtl/vga_pixel_compositor_if.sv
// Pixel-path bundle between timing controller, framebuffer, console overlay and compositor.
interface vga_pixel_compositor_if #(
  parameter int COLOR_BITS = 6,
  parameter int IMG_W_BITS = 8,
  parameter int IMG_H_BITS = 8
);
  localparam int CW = 3 * COLOR_BITS;
  localparam int AW = IMG_W_BITS + IMG_H_BITS;

  logic [11:0]   x_in;
  logic [11:0]   y_in;
  logic          active_in;
  logic          hsync_in;
  logic          vsync_in;
  logic [1:0]    cfg_scale;
  logic [11:0]   cfg_x_off;
  logic [11:0]   cfg_y_off;
  logic [1:0]    cfg_mode;
  logic [CW-1:0] cfg_fg;
  logic [CW-1:0] cfg_border;
  logic          ovl_bit;
  logic [AW-1:0] mem_addr;
  logic          mem_rd_en;
  logic [CW-1:0] mem_data;
  logic [CW-1:0] rgb_out;
  logic          hsync_out;
  logic          vsync_out;
  logic          active_out;
  logic [15:0]   frame_count;

  modport master (
    output x_in, y_in, active_in, hsync_in, vsync_in,
    output cfg_scale, cfg_x_off, cfg_y_off, cfg_mode, cfg_fg, cfg_border,
    output ovl_bit, mem_data,
    input  mem_addr, mem_rd_en, rgb_out, hsync_out, vsync_out, active_out, frame_count
  );

  modport slave (
    input  x_in, y_in, active_in, hsync_in, vsync_in,
    input  cfg_scale, cfg_x_off, cfg_y_off, cfg_mode, cfg_fg, cfg_border,
    input  ovl_bit, mem_data,
    output mem_addr, mem_rd_en, rgb_out, hsync_out, vsync_out, active_out, frame_count
  );
endinterface

// File: rtl/vga_pixel_compositor.sv
// Scaled/offset framebuffer fetch, console overlay and test bars; rgb and syncs emerge MEM_LATENCY+2 clocks
// after the coordinate, one pixel per clock. Config is shadowed at the VSYNC assert edge.
module vga_pixel_compositor #(
  parameter int COLOR_BITS  = 6,
  parameter int IMG_W_BITS  = 8,
  parameter int IMG_H_BITS  = 8,
  parameter int MEM_LATENCY = 1,
  parameter int OVL_LATENCY = 1,
  parameter int VSYNC_POL   = 0,
  parameter int BAR_SHIFT   = 7
) (
  input logic                    clk_pixel,
  input logic                    reset,
  vga_pixel_compositor_if.slave  bus
);
  localparam int   CW      = 3 * COLOR_BITS;
  localparam int   AW      = IMG_W_BITS + IMG_H_BITS;
  localparam int   LAT     = MEM_LATENCY + 2;
  localparam int   OVL_DLY = MEM_LATENCY + 1 - OVL_LATENCY;
  localparam logic VS_ACT  = 1'(VSYNC_POL);

  logic [1:0]    r_scale, r_mode;
  logic [11:0]   r_x_off, r_y_off;
  logic [CW-1:0] r_fg, r_border;
  logic          r_vs_prev;
  logic [15:0]   r_frame_cnt;
  logic          w_vs_edge;

  // Previous-vsync reset value is the active level so an in-progress vsync is not seen as a new edge.
  assign w_vs_edge = (bus.vsync_in == VS_ACT) && (r_vs_prev != VS_ACT);

  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      r_scale     <= 2'd2;
      r_mode      <= 2'd0;
      r_x_off     <= '0;
      r_y_off     <= '0;
      r_fg        <= '1;
      r_border    <= '0;
      r_vs_prev   <= VS_ACT;
      r_frame_cnt <= '0;
    end else begin
      r_vs_prev <= bus.vsync_in;
      if (w_vs_edge) begin
        r_scale     <= bus.cfg_scale;
        r_mode      <= bus.cfg_mode;
        r_x_off     <= bus.cfg_x_off;
        r_y_off     <= bus.cfg_y_off;
        r_fg        <= bus.cfg_fg;
        r_border    <= bus.cfg_border;
        r_frame_cnt <= r_frame_cnt + 16'd1;
      end
    end
  end

  logic [12:0] w_dx, w_dy, w_img_x, w_img_y;
  logic        w_inside, w_rd_en;

  // Bit 12 of the difference is the sign; shifted values are only meaningful when it is clear.
  assign w_dx     = {1'b0, bus.x_in} - {1'b0, r_x_off};
  assign w_dy     = {1'b0, bus.y_in} - {1'b0, r_y_off};
  assign w_img_x  = w_dx >> r_scale;
  assign w_img_y  = w_dy >> r_scale;
  assign w_inside = bus.active_in && !w_dx[12] && !w_dy[12] &&
                    ((w_img_x >> IMG_W_BITS) == 13'd0) && ((w_img_y >> IMG_H_BITS) == 13'd0);
  assign w_rd_en  = w_inside && (r_mode != 2'd3);

  logic          r_rd_en;
  logic [AW-1:0] r_addr;
  logic          r_ins [MEM_LATENCY+1];
  logic [2:0]    r_bar [MEM_LATENCY+1];
  logic [LAT-1:0] r_hs_dly, r_vs_dly, r_act_dly;

  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      r_rd_en   <= 1'b0;
      r_addr    <= '0;
      r_hs_dly  <= '0;
      r_vs_dly  <= '0;
      r_act_dly <= '0;
      for (int i = 0; i <= MEM_LATENCY; i++) begin
        r_ins[i] <= 1'b0;
        r_bar[i] <= '0;
      end
    end else begin
      r_rd_en <= w_rd_en;
      if (w_rd_en) r_addr <= {w_img_y[IMG_H_BITS-1:0], w_img_x[IMG_W_BITS-1:0]};
      r_ins[0] <= w_inside;
      r_bar[0] <= bus.x_in[BAR_SHIFT+2:BAR_SHIFT];
      for (int i = 1; i <= MEM_LATENCY; i++) begin
        r_ins[i] <= r_ins[i-1];
        r_bar[i] <= r_bar[i-1];
      end
      r_hs_dly  <= {r_hs_dly[LAT-2:0], bus.hsync_in};
      r_vs_dly  <= {r_vs_dly[LAT-2:0], bus.vsync_in};
      r_act_dly <= {r_act_dly[LAT-2:0], bus.active_in};
    end
  end

  logic w_ovl;

  generate
    if (OVL_DLY == 0) begin : g_ovl_direct
      assign w_ovl = bus.ovl_bit;
    end else begin : g_ovl_pipe
      logic r_ovl_dly [OVL_DLY];
      always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
          for (int i = 0; i < OVL_DLY; i++) r_ovl_dly[i] <= 1'b0;
        end else begin
          r_ovl_dly[0] <= bus.ovl_bit;
          for (int i = 1; i < OVL_DLY; i++) r_ovl_dly[i] <= r_ovl_dly[i-1];
        end
      end
      assign w_ovl = r_ovl_dly[OVL_DLY-1];
    end
  endgenerate

  logic          w_act_f, w_ins_f;
  logic [2:0]    w_bar_f;
  logic [CW-1:0] w_bar_rgb, w_pix, r_rgb;

  // Stage metadata is tapped where it lines up with mem_data, one clock before the output register.
  assign w_act_f   = r_act_dly[MEM_LATENCY];
  assign w_ins_f   = r_ins[MEM_LATENCY];
  assign w_bar_f   = r_bar[MEM_LATENCY];
  assign w_bar_rgb = {{COLOR_BITS{w_bar_f[2]}}, {COLOR_BITS{w_bar_f[1]}}, {COLOR_BITS{w_bar_f[0]}}};

  always_comb begin
    w_pix = '0;
    if (!w_act_f) begin
      w_pix = '0;
    end else if (r_mode == 2'd3) begin
      w_pix = w_bar_rgb;
    end else if (!w_ins_f) begin
      w_pix = r_border;
    end else begin
      case (r_mode)
        2'd0:    w_pix = w_ovl ? r_fg : bus.mem_data;
        2'd2:    w_pix = w_ovl ? ~bus.mem_data : bus.mem_data;
        default: w_pix = bus.mem_data;
      endcase
    end
  end

  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) r_rgb <= '0;
    else       r_rgb <= w_pix;
  end

  assign bus.mem_addr    = r_addr;
  assign bus.mem_rd_en   = r_rd_en;
  assign bus.rgb_out     = r_rgb;
  assign bus.hsync_out   = r_hs_dly[LAT-1];
  assign bus.vsync_out   = r_vs_dly[LAT-1];
  assign bus.active_out  = r_act_dly[LAT-1];
  assign bus.frame_count = r_frame_cnt;
endmodule

// File: tb/tb_vga_pixel_compositor.sv
// Directed bench: u_dut1 (MEM_LATENCY 1) carries the functional checks; u_dut3 (MEM_LATENCY 3) shares its
// inputs for reset, sync-alignment and frame-count checks.
module tb_vga_pixel_compositor;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  vga_pixel_compositor_if #(.COLOR_BITS(6), .IMG_W_BITS(8), .IMG_H_BITS(8)) bus1 ();
  vga_pixel_compositor_if #(.COLOR_BITS(6), .IMG_W_BITS(8), .IMG_H_BITS(8)) bus3 ();

  vga_pixel_compositor #(.MEM_LATENCY(1), .OVL_LATENCY(1)) u_dut1 (
    .clk_pixel (clk),
    .reset     (rst),
    .bus       (bus1)
  );

  vga_pixel_compositor #(.MEM_LATENCY(3), .OVL_LATENCY(2)) u_dut3 (
    .clk_pixel (clk),
    .reset     (rst),
    .bus       (bus3)
  );

  assign bus3.x_in       = bus1.x_in;
  assign bus3.y_in       = bus1.y_in;
  assign bus3.active_in  = bus1.active_in;
  assign bus3.hsync_in   = bus1.hsync_in;
  assign bus3.vsync_in   = bus1.vsync_in;
  assign bus3.cfg_scale  = bus1.cfg_scale;
  assign bus3.cfg_x_off  = bus1.cfg_x_off;
  assign bus3.cfg_y_off  = bus1.cfg_y_off;
  assign bus3.cfg_mode   = bus1.cfg_mode;
  assign bus3.cfg_fg     = bus1.cfg_fg;
  assign bus3.cfg_border = bus1.cfg_border;
  assign bus3.ovl_bit    = bus1.ovl_bit;

  // Framebuffer models: the word stored at an address is the address itself, zero-extended.
  logic [17:0] m3_q [2];
  always @(posedge clk) bus1.mem_data <= {2'b00, bus1.mem_addr};
  always @(posedge clk) begin
    m3_q[0]       <= {2'b00, bus3.mem_addr};
    m3_q[1]       <= m3_q[0];
    bus3.mem_data <= m3_q[1];
  end

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic vsync_pulse();
    bus1.vsync_in = 1'b0;
    step(1);
    bus1.vsync_in = 1'b1;
    step(1);
  endtask

  task automatic set_defaults();
    bus1.cfg_scale  = 2'd2;
    bus1.cfg_x_off  = 12'd0;
    bus1.cfg_y_off  = 12'd0;
    bus1.cfg_mode   = 2'd0;
    bus1.cfg_fg     = 18'h3FFFF;
    bus1.cfg_border = 18'h00000;
  endtask

  task automatic test_reset();
    bus1.x_in = 12'd0; bus1.y_in = 12'd0; bus1.active_in = 1'b0;
    bus1.hsync_in = 1'b1; bus1.vsync_in = 1'b1; bus1.ovl_bit = 1'b0;
    set_defaults();
    rst = 1'b1;
    step(2);
    n_checks++;
    if (bus1.rgb_out !== 18'h0) begin
      n_fail++; $display("FAIL reset_rgb: got %h expected 0", bus1.rgb_out);
    end
    n_checks++;
    if ({bus1.mem_rd_en, bus1.mem_addr} !== 17'h0) begin
      n_fail++; $display("FAIL reset_mem: got rd_en=%b addr=%h expected 0/0", bus1.mem_rd_en, bus1.mem_addr);
    end
    n_checks++;
    if ({bus1.hsync_out, bus1.vsync_out, bus1.active_out} !== 3'b000) begin
      n_fail++; $display("FAIL reset_syncs: got %b expected 000", {bus1.hsync_out, bus1.vsync_out, bus1.active_out});
    end
    n_checks++;
    if (bus1.frame_count !== 16'd0) begin
      n_fail++; $display("FAIL reset_frame: got %0d expected 0", bus1.frame_count);
    end
    n_checks++;
    if ({bus3.rgb_out, bus3.hsync_out, bus3.vsync_out, bus3.active_out, bus3.mem_rd_en, bus3.frame_count} !== '0) begin
      n_fail++; $display("FAIL reset_dut3: got rgb=%h frame=%0d expected all zero", bus3.rgb_out, bus3.frame_count);
    end
    rst = 1'b0;
    step(1);
  endtask

  task automatic test_default_addr();
    bus1.x_in = 12'd4; bus1.y_in = 12'd8; bus1.active_in = 1'b1;
    step(1);
    n_checks++;
    if ({bus1.mem_rd_en, bus1.mem_addr} !== {1'b1, 16'h0201}) begin
      n_fail++; $display("FAIL default_addr: got rd_en=%b addr=%h expected 1/0201", bus1.mem_rd_en, bus1.mem_addr);
    end
    step(2);
    n_checks++;
    if ({bus1.rgb_out, bus1.active_out} !== {18'h00201, 1'b1}) begin
      n_fail++; $display("FAIL default_rgb: got rgb=%h act=%b expected 00201/1", bus1.rgb_out, bus1.active_out);
    end
  endtask

  task automatic test_overlay();
    bus1.ovl_bit = 1'b1;
    step(4);
    n_checks++;
    if (bus1.rgb_out !== 18'h3FFFF) begin
      n_fail++; $display("FAIL ovl_opaque: got %h expected 3ffff", bus1.rgb_out);
    end
    bus1.cfg_mode = 2'd2;
    vsync_pulse();
    bus1.x_in = 12'd60; bus1.y_in = 12'd60;
    step(4);
    n_checks++;
    if (bus1.rgb_out !== 18'h3F0F0) begin
      n_fail++; $display("FAIL ovl_invert: got %h expected 3f0f0", bus1.rgb_out);
    end
    bus1.ovl_bit = 1'b0;
    step(4);
    n_checks++;
    if (bus1.rgb_out !== 18'h00F0F) begin
      n_fail++; $display("FAIL invert_no_ovl: got %h expected 00f0f", bus1.rgb_out);
    end
    bus1.cfg_mode = 2'd1;
    vsync_pulse();
    bus1.ovl_bit = 1'b1;
    step(4);
    n_checks++;
    if (bus1.rgb_out !== 18'h00F0F) begin
      n_fail++; $display("FAIL image_only: got %h expected 00f0f", bus1.rgb_out);
    end
    bus1.ovl_bit = 1'b0;
  endtask

  task automatic test_clip();
    logic [11:0] xs [4];
    logic        rd [4];
    logic [15:0] ad [4];
    logic [17:0] px [4];
    logic        ov [4];
    xs = '{12'd99, 12'd100, 12'd355, 12'd356};
    rd = '{1'b0, 1'b1, 1'b1, 1'b0};
    ad = '{16'h0F0F, 16'h0500, 16'h05FF, 16'h05FF};
    px = '{18'h2AAAA, 18'h00500, 18'h005FF, 18'h2AAAA};
    ov = '{1'b0, 1'b0, 1'b0, 1'b1};
    set_defaults();
    bus1.cfg_scale = 2'd0; bus1.cfg_x_off = 12'd100; bus1.cfg_border = 18'h2AAAA;
    vsync_pulse();
    bus1.y_in = 12'd5;
    for (int i = 0; i < 4; i++) begin
      bus1.x_in = xs[i];
      bus1.ovl_bit = ov[i];
      step(1);
      n_checks++;
      if (bus1.mem_rd_en !== rd[i] || (rd[i] && bus1.mem_addr !== ad[i])) begin
        n_fail++; $display("FAIL clip_fetch x=%0d: got rd_en=%b addr=%h expected %b/%h",
                           xs[i], bus1.mem_rd_en, bus1.mem_addr, rd[i], ad[i]);
      end
      step(3);
      n_checks++;
      if (bus1.rgb_out !== px[i]) begin
        n_fail++; $display("FAIL clip_rgb x=%0d: got %h expected %h", xs[i], bus1.rgb_out, px[i]);
      end
    end
    bus1.ovl_bit = 1'b0;
    bus1.cfg_x_off = 12'd4000;
    vsync_pulse();
    for (int x = 0; x < 640; x += 213) begin
      bus1.x_in = 12'(x);
      step(3);
      n_checks++;
      if (bus1.mem_rd_en !== 1'b0 || bus1.rgb_out !== 18'h2AAAA) begin
        n_fail++; $display("FAIL offscreen x=%0d: got rd_en=%b rgb=%h expected 0/2aaaa", x, bus1.mem_rd_en, bus1.rgb_out);
      end
    end
    bus1.active_in = 1'b0;
    step(3);
    n_checks++;
    if (bus1.rgb_out !== 18'h0) begin
      n_fail++; $display("FAIL blank_rgb: got %h expected 0", bus1.rgb_out);
    end
    bus1.active_in = 1'b1;
  endtask

  task automatic test_mode3_shadow();
    logic [11:0] xs [5];
    logic [17:0] px [5];
    xs = '{12'd64, 12'd200, 12'd300, 12'd500, 12'd600};
    px = '{18'h00000, 18'h0003F, 18'h00FC0, 18'h00FFF, 18'h3F000};
    set_defaults();
    vsync_pulse();
    bus1.cfg_mode = 2'd3;
    bus1.x_in = 12'd64; bus1.y_in = 12'd8;
    step(1);
    n_checks++;
    if ({bus1.mem_rd_en, bus1.mem_addr} !== {1'b1, 16'h0210}) begin
      n_fail++; $display("FAIL shadow_addr: got rd_en=%b addr=%h expected 1/0210", bus1.mem_rd_en, bus1.mem_addr);
    end
    step(2);
    n_checks++;
    if (bus1.rgb_out !== 18'h00210) begin
      n_fail++; $display("FAIL shadow_hold: got %h expected 00210", bus1.rgb_out);
    end
    vsync_pulse();
    for (int i = 0; i < 5; i++) begin
      bus1.x_in = xs[i];
      step(1);
      n_checks++;
      if (bus1.mem_rd_en !== 1'b0) begin
        n_fail++; $display("FAIL bars_rd_en x=%0d: got %b expected 0", xs[i], bus1.mem_rd_en);
      end
      step(2);
      n_checks++;
      if (bus1.rgb_out !== px[i]) begin
        n_fail++; $display("FAIL bars_rgb x=%0d: got %h expected %h", xs[i], bus1.rgb_out, px[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  ovl_pat;
    logic [17:0] exp_px;
    ovl_pat = 8'b0010_0100;
    set_defaults();
    vsync_pulse();
    bus1.y_in = 12'd12;
    for (int i = 0; i < 8 + 3 - 1; i++) begin
      bus1.active_in = (i < 8);
      bus1.x_in      = 12'(4 * i);
      bus1.ovl_bit   = (i >= 1 && i <= 8) ? ovl_pat[i-1] : 1'b0;
      step(1);
      if (i + 1 - 3 >= 0) begin
        exp_px = ovl_pat[i-2] ? 18'h3FFFF : 18'h00300 + 18'(i - 2);
        n_checks++;
        if (bus1.rgb_out !== exp_px) begin
          n_fail++; $display("FAIL stream pixel %0d: got %h expected %h", i - 2, bus1.rgb_out, exp_px);
        end
      end
    end
    bus1.ovl_bit = 1'b0;
  endtask

  task automatic test_sync_align();
    logic [2:0] hist [40];
    bus1.x_in = 12'd0; bus1.y_in = 12'd0;
    for (int i = 0; i < 40; i++) begin
      hist[i] = {(i % 5) != 0, (i % 11) < 8, (i % 3) != 2};
      {bus1.hsync_in, bus1.vsync_in, bus1.active_in} = hist[i];
      step(1);
      if (i >= 2) begin
        n_checks++;
        if ({bus1.hsync_out, bus1.vsync_out, bus1.active_out} !== hist[i-2]) begin
          n_fail++; $display("FAIL sync_lat3 cycle %0d: got %b expected %b", i,
                             {bus1.hsync_out, bus1.vsync_out, bus1.active_out}, hist[i-2]);
        end
      end
      if (i >= 4) begin
        n_checks++;
        if ({bus3.hsync_out, bus3.vsync_out, bus3.active_out} !== hist[i-4]) begin
          n_fail++; $display("FAIL sync_lat5 cycle %0d: got %b expected %b", i,
                             {bus3.hsync_out, bus3.vsync_out, bus3.active_out}, hist[i-4]);
        end
      end
    end
    bus1.hsync_in = 1'b1; bus1.vsync_in = 1'b1;
  endtask

  task automatic test_reset_midframe();
    bus1.x_in = 12'd4; bus1.y_in = 12'd8; bus1.active_in = 1'b1;
    step(4);
    bus1.cfg_mode = 2'd3; bus1.cfg_scale = 2'd0;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({bus1.rgb_out, bus1.hsync_out, bus1.vsync_out, bus1.active_out, bus1.mem_rd_en} !== '0) begin
      n_fail++; $display("FAIL midreset_outputs: got rgb=%h syncs=%b expected all zero",
                         bus1.rgb_out, {bus1.hsync_out, bus1.vsync_out, bus1.active_out});
    end
    n_checks++;
    if (bus1.frame_count !== 16'd0 || bus3.frame_count !== 16'd0) begin
      n_fail++; $display("FAIL midreset_frame: got %0d/%0d expected 0/0", bus1.frame_count, bus3.frame_count);
    end
    #2;
    rst = 1'b0;
    step(4);
    n_checks++;
    if (bus1.rgb_out !== 18'h00201) begin
      n_fail++; $display("FAIL midreset_defaults: got %h expected 00201", bus1.rgb_out);
    end
    vsync_pulse();
    vsync_pulse();
    n_checks++;
    if (bus1.frame_count !== 16'd2 || bus3.frame_count !== 16'd2) begin
      n_fail++; $display("FAIL frame_after_two: got %0d/%0d expected 2/2", bus1.frame_count, bus3.frame_count);
    end
  endtask

  initial begin
    test_reset();
    test_default_addr();
    test_overlay();
    test_clip();
    test_mode3_shadow();
    test_back_to_back();
    test_sync_align();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
